// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-divider controller.
//   state_t   : controller FSM states
//   DIV_MIN   : smallest legal divide ratio
//   DIV_W_DEF : default ratio/counter width
//   fsm_next  : next-state function for the controller FSM
package clk_div_pkg;

  localparam int unsigned DIV_W_DEF = 8;
  localparam int unsigned DIV_MIN   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  // acc_ok: a legal ratio is accepted this cycle; bnd: last cycle of the period.
  function automatic state_t fsm_next(input state_t s, input logic en,
                                      input logic acc_ok, input logic bnd);
    state_t n;
    n = s;
    case (s)
      IDLE: if (en) n = RUN;
      // A new ratio wins over a stop request; PEND then lands in IDLE if en is low.
      RUN:  if (acc_ok) n = PEND;
            else if (!en) n = STOP;
      PEND: if (bnd) n = en ? RUN : IDLE;
      STOP: if (en) n = RUN;
            else if (bnd) n = IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter, boundary detect and clk_out/tick generation.
// Ports:
//   clk_in, rst_n : clock, async active-low reset
//   run           : counter advances when high, held at 0 when low
//   load/load_div : replace the ratio in effect (takes effect next cycle)
//   cur_div       : ratio in effect
//   boundary_c    : combinational, last cycle of the current period
//   clk_out       : divided clock, low floor(N/2) then high ceil(N/2)
//   tick          : one-cycle pulse in the cycle after each boundary
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned DIV_DEFAULT = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic [DIV_W-1:0] cur_div,
  output logic             boundary_c,
  output logic             clk_out,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // cur_div >= 2 always, so the subtraction cannot underflow.
  assign boundary_c = run && (cnt == (cur_div - DIV_W'(1)));

  // Counter, output clock and tick registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      cur_div <= DIV_W'(DIV_DEFAULT);
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (!run || boundary_c) cnt <= '0;
      else                    cnt <= cnt + DIV_W'(1);
      clk_out <= run && (cnt >= (cur_div >> 1));
      tick    <= boundary_c;
      if (load) cur_div <= load_div;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for a programmable integer clock divider: start/stop
// sequencing and glitch-free ratio changes applied only at period boundaries.
// Optional feature macro: CLK_DIV_CTRL_PERIOD_CNT_EN adds a 16-bit period_cnt
// output counting ticks since the last ratio change.
// Ports:
//   clk_in, rst_n        : clock, async active-low reset
//   en                   : run request (level)
//   cfg_valid/cfg_div    : offered ratio; cfg_ready accepts it
//   cfg_err              : one-cycle pulse after an illegal (N<2) ratio is accepted
//   cur_div              : ratio in effect
//   clk_out, tick        : divided clock and end-of-period pulse
//   busy                 : controller not idle
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned DIV_DEFAULT = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [DIV_W-1:0] cur_div,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] pend_div;
  logic             boundary;
  logic             legal;
  logic             accept;
  logic             acc_ok;
  logic             acc_bad;
  logic             load;
  logic [DIV_W-1:0] load_div;

  assign legal    = (cfg_div >= DIV_W'(DIV_MIN));
  assign accept   = cfg_valid && cfg_ready;
  assign acc_ok   = accept && legal;
  assign acc_bad  = accept && !legal;

  // Idle accepts apply immediately; running accepts wait in PEND for the boundary.
  assign load     = ((state == IDLE) && acc_ok) || ((state == PEND) && boundary);
  assign load_div = (state == PEND) ? pend_div : cfg_div;

  assign state_nxt = fsm_next(state, en, acc_ok, boundary);

  // FSM state and registered status outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend_div  <= '0;
      cfg_err   <= 1'b0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_ready <= (state_nxt == IDLE) || (state_nxt == RUN);
      busy      <= (state_nxt != IDLE);
      cfg_err   <= acc_bad;
      if ((state == RUN) && acc_ok) pend_div <= cfg_div;
    end
  end

  clk_div_core #(
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_core (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .run        (state != IDLE),
    .load       (load),
    .load_div   (load_div),
    .cur_div    (cur_div),
    .boundary_c (boundary),
    .clk_out    (clk_out),
    .tick       (tick)
  );

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  // Ticks since the last ratio change; wraps naturally at 16 bits.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)    period_cnt <= '0;
    else if (load) period_cnt <= '0;
    else if (tick) period_cnt <= period_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl with hand-derived expectations.
module tb_clk_div_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic [7:0] cur_div;
  logic       clk_out;
  logic       tick;
  logic       busy;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] rec;
  int          ticks;
  logic        busy_all;

  always #5 clk_in = ~clk_in;

  clk_div_ctrl #(
    .DIV_W       (8),
    .DIV_DEFAULT (2)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .cur_div    (cur_div),
    .clk_out    (clk_out),
    .tick       (tick),
    .busy       (busy)
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic step_rec();
    step();
    rec = {rec[30:0], clk_out};
    if (tick) ticks++;
    busy_all = busy_all & busy;
  endtask

  task automatic clear_rec();
    rec = '0;
    ticks = 0;
    busy_all = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    cfg_valid = 1'b0;
    cfg_div = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Load ratio n in IDLE, then enable; returns with RUN entered and cnt=0.
  task automatic start(input logic [7:0] n);
    cfg_valid = 1'b1;
    cfg_div = n;
    step();
    cfg_valid = 1'b0;
    en = 1'b1;
    step();
    clear_rec();
  endtask

  initial begin
    // Reset values and default ratio of 2.
    do_reset();
    check("rst_cur_div", 32'(cur_div), 32'd2);
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    en = 1'b1;
    step();
    check("n2_busy", 32'(busy), 32'd1);
    clear_rec();
    repeat (6) step_rec();
    check("n2_pattern", 32'(rec[5:0]), 32'b010101);
    check("n2_ticks", 32'(ticks), 32'd3);
    en = 1'b0;
    repeat (4) step();
    check("n2_stop_busy", 32'(busy), 32'd0);
    check("n2_stop_clk", 32'(clk_out), 32'd0);

    // Ratio 5 loaded in IDLE.
    do_reset();
    cfg_valid = 1'b1;
    cfg_div = 8'd5;
    check("n5_ready", 32'(cfg_ready), 32'd1);
    step();
    check("n5_cur_div", 32'(cur_div), 32'd5);
    cfg_valid = 1'b0;
    en = 1'b1;
    step();
    clear_rec();
    repeat (10) step_rec();
    check("n5_pattern", 32'(rec[9:0]), 32'b0011100111);
    check("n5_ticks", 32'(ticks), 32'd2);

    // Change 4 -> 7 mid-period.
    do_reset();
    start(8'd4);
    step_rec();
    cfg_valid = 1'b1;
    cfg_div = 8'd7;
    step_rec();
    check("chg_ready_low", 32'(cfg_ready), 32'd0);
    check("chg_busy", 32'(busy), 32'd1);
    cfg_valid = 1'b0;
    step_rec();
    check("chg_old_div", 32'(cur_div), 32'd4);
    step_rec();
    check("chg_new_div", 32'(cur_div), 32'd7);
    check("chg_ready_back", 32'(cfg_ready), 32'd1);
    repeat (8) step_rec();
    check("chg_pattern", 32'(rec[11:0]), 32'b001100011110);

    // Illegal ratio 1 while running at 3.
    do_reset();
    start(8'd3);
    step_rec();
    cfg_valid = 1'b1;
    cfg_div = 8'd1;
    step_rec();
    cfg_valid = 1'b0;
    check("ill_err_pulse", 32'(cfg_err), 32'd1);
    check("ill_ready", 32'(cfg_ready), 32'd1);
    check("ill_cur_div", 32'(cur_div), 32'd3);
    step_rec();
    check("ill_err_clear", 32'(cfg_err), 32'd0);
    repeat (6) step_rec();
    check("ill_pattern", 32'(rec[8:0]), 32'b011011011);

    // Stop at 6: period finishes, then IDLE.
    do_reset();
    start(8'd6);
    step_rec();
    en = 1'b0;
    repeat (4) step_rec();
    check("stop_busy_mid", 32'(busy), 32'd1);
    step_rec();
    check("stop_busy_end", 32'(busy), 32'd0);
    check("stop_tick", 32'(tick), 32'd1);
    step_rec();
    check("stop_pattern", 32'(rec[6:0]), 32'b0001110);
    check("stop_clk_low", 32'(clk_out), 32'd0);

    // Stop then re-enable before the boundary: no gap.
    do_reset();
    start(8'd6);
    step_rec();
    en = 1'b0;
    step_rec();
    step_rec();
    en = 1'b1;
    repeat (11) step_rec();
    check("reen_pattern", 32'(rec[13:0]), 32'b00011100011100);
    check("reen_busy", 32'(busy_all), 32'd1);
    check("reen_ticks", 32'(ticks), 32'd2);

    // Accept on the boundary cycle: applied at the following boundary.
    do_reset();
    start(8'd4);
    repeat (3) step_rec();
    cfg_valid = 1'b1;
    cfg_div = 8'd2;
    step();
    cfg_valid = 1'b0;
    check("bnd_ready_low", 32'(cfg_ready), 32'd0);
    repeat (3) step();
    check("bnd_still_old", 32'(cur_div), 32'd4);
    step();
    check("bnd_applied", 32'(cur_div), 32'd2);
    check("bnd_ready_back", 32'(cfg_ready), 32'd1);

    // Reset while PEND: pending ratio is lost.
    do_reset();
    start(8'd4);
    cfg_valid = 1'b1;
    cfg_div = 8'd9;
    step();
    cfg_valid = 1'b0;
    check("pend_ready_low", 32'(cfg_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cur_div", 32'(cur_div), 32'd2);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(cfg_ready), 32'd1);
    check("arst_clk", 32'(clk_out), 32'd0);
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    step();
    clear_rec();
    repeat (8) step_rec();
    check("arst_pattern", 32'(rec[7:0]), 32'b01010101);
    check("arst_div_kept", 32'(cur_div), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
